cellular_ram_responder: RTL and testbench
=========================================

# cellular_ram_responder

Synthesizable memory-side model of the Micron-style cellular RAM that the FPGA RAM controller drives. It responds to the controller's address, data, byte-select and strobe signals plus `mt_adv`/`mt_cre`/`mt_ce`/`mt_clk`, and returns read data and `mt_wait`. It supports a 16-bit array with byte lanes, a configuration register (BCR), fixed access latencies and wrapped read bursts. It replaces the physical RAM in simulation and loopback builds.

## Interface
- `ADDRESS_SIZE`, 23: memory address bus width.
- `DATA_SIZE`, 16: data bus width; fixed at 16 (byte lanes assumed).
- `MEM_ADDR_BITS`, 10: implemented array depth is 2^MEM_ADDR_BITS words. Higher address bits are ignored (aliasing).
- `READ_LATENCY`, 4: cycles `mt_wait` stays high before read data is valid; ≥1.
- `WRITE_LATENCY`, 2: cycles `mt_wait` stays high before a write commits; ≥1.
- `BURST_LEN`, 4: read burst wrap length; power of two, ≤2^MEM_ADDR_BITS.

- `clk` in 1: single clock; all inputs sampled on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mt_addr` in ADDRESS_SIZE: address, or BCR value during a CRE write.
- `mt_data` inout DATA_SIZE: data bus; high-Z unless driving read data.
- `mt_lb` in 1: lower byte enable, active-low.
- `mt_ub` in 1: upper byte enable, active-low.
- `mt_oe` in 1: output enable, active-low.
- `mt_we` in 1: write enable, active-low.
- `mt_ce` in 1: chip enable, active-low.
- `mt_adv` in 1: address valid, active-low.
- `mt_cre` in 1: configuration register enable, active-high.
- `mt_clk` in 1: burst advance clock, sampled by `clk` and rising-edge detected.
- `mt_wait` out 1: active-high; 1 = access in progress, data not valid.

## Operation
- States: IDLE, WAIT_RD, READ, WAIT_WR, WRITE, CFG, DONE.
- **IDLE:** `mt_wait`=0, bus high-Z. On `mt_ce`=0 && `mt_adv`=0, latch `addr_q`.
  - `mt_cre`=1 → CFG.
  - Otherwise `mt_we`=0 → WAIT_WR with the counter loaded to WRITE_LATENCY.
  - Otherwise → WAIT_RD with the counter loaded to READ_LATENCY.
- **WAIT_RD / WAIT_WR:** `mt_wait`=1; the counter decrements each cycle.
  - At count 1, WAIT_RD → READ and loads `rd_q` = mem[`addr_q`].
  - At count 1, WAIT_WR → WRITE.
- **READ:** `mt_wait`=0.
  - `mt_data` = `rd_q` while `mt_oe`=0 && `mt_we`=1 && `mt_ce`=0; otherwise high-Z.
  - `mt_lb`/`mt_ub` do not gate reads; all 16 bits are driven.
  - A detected `mt_clk` rising edge with `mt_adv`=1 increments the low log2(BURST_LEN) bits of `addr_q` modulo BURST_LEN; upper bits are unchanged.
  - `rd_q` reloads one cycle after each advance.
- **WRITE:** on this edge, if `mt_we`=0 && `mt_ce`=0, commit `mt_data[7:0]` when `mt_lb`=0 and `mt_data[15:8]` when `mt_ub`=0.
  - Both byte enables high: no change.
  - `mt_we` already high: no commit (write abandoned).
  - Next state: DONE.
- **CFG:**
  - `mt_we`=0: BCR ← latched `addr_q[15:0]`, then → DONE.
  - `mt_oe`=0 && `mt_we`=1: drive BCR on `mt_data`; remain in CFG.
- **DONE:** `mt_wait`=0, bus high-Z; hold until `mt_ce`=1.
- **Chip deselect:** `mt_ce`=1 sampled in any state → IDLE on the next edge. `mt_wait` clears and the bus releases. A pending write is discarded; a read is aborted.
- **Read-after-write:** a read of the same address after a committed write returns the new data.

## Timing
- **Reset (`rst`=0, immediate):**
  - State IDLE, `mt_wait`=0, `mt_data` high-Z.
  - BCR = 16'h9D1F; counter = 0; `addr_q` = 0; `mt_clk` edge-detect register = 0.
  - Array contents are not reset.
- **Reset mid-access:** returns to IDLE immediately with no array write.
- **Read latency:** address latched at edge k. `mt_wait`=1 for cycles k+1 … k+READ_LATENCY. Valid data and `mt_wait`=0 appear in cycle k+READ_LATENCY+1.
- **Write latency:** latched at edge k; `mt_wait`=1 for WRITE_LATENCY cycles; commit at edge k+WRITE_LATENCY+1.
- **Burst:** `mt_clk` rise detected at edge j → new word on `mt_data` from cycle j+2.
- `mt_clk` edges outside READ are ignored.
- `mt_adv` low re-sampled while already active (not IDLE) is ignored; a new access requires a `mt_ce` high gap.
- The `mt_data` output enable is combinational from state and `mt_oe`/`mt_we`/`mt_ce`. The data value comes from registers only.

## Test plan
- **Reset:** `rst`=0 → `mt_wait`=0, `mt_data`=Z, BCR=16'h9D1F. A CRE read after reset returns 16'h9D1F.
- **Write/read:** write 16'hA55A to address 0x005 with both bytes enabled, then read 0x005 → `mt_wait` high exactly 4 cycles, then `mt_data`=16'hA55A.
- **Byte lanes:**
  - Over 16'hA55A, write 16'h1234 with `mt_ub`=1 → read returns 16'hA534.
  - Then write 16'hFF00 with `mt_lb`=1 → read returns 16'hFF34.
- **Burst wrap:** preload 0x008..0x00B with 1..4, start a read at 0x00A, give 4 `mt_clk` pulses → sequence 3,4,1,2,3.
- **Abort:**
  - Raise `mt_ce` during WAIT_WR on address 0x010 (old value 16'h0000) → the read-back stays 16'h0000 and `mt_wait` is 0 the next cycle.
  - Raise `mt_ce` mid-read → bus high-Z the next cycle.
- **Config and aliasing:**
  - CRE write with `mt_addr`=0x001234 → a CRE read returns 16'h1234.
  - Address 0x400 aliases to 0x000 for MEM_ADDR_BITS=10.

Source files
------------

// File: rtl/cellular_ram_responder.sv
// Memory-side model of a Micron-style cellular RAM: 16-bit array with byte lanes,
// BCR configuration register, fixed wait-state latencies and wrapped read bursts.
module cellular_ram_responder #(
    parameter int ADDRESS_SIZE  = 23,
    parameter int DATA_SIZE     = 16,
    parameter int MEM_ADDR_BITS = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int BURST_LEN     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] mt_addr,
    inout  wire  [DATA_SIZE-1:0]    mt_data,
    input  logic                    mt_lb,
    input  logic                    mt_ub,
    input  logic                    mt_oe,
    input  logic                    mt_we,
    input  logic                    mt_ce,
    input  logic                    mt_adv,
    input  logic                    mt_cre,
    input  logic                    mt_clk,
    output logic                    mt_wait
);

    localparam int MAX_LATENCY = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_BITS    = $clog2(MAX_LATENCY + 1);
    localparam int MEM_DEPTH   = 1 << MEM_ADDR_BITS;

    localparam logic [DATA_SIZE-1:0]    BCR_RESET  = DATA_SIZE'(16'h9D1F);
    localparam logic [ADDRESS_SIZE-1:0] BURST_MASK = ADDRESS_SIZE'(BURST_LEN - 1);
    localparam logic [CNT_BITS-1:0]     CNT_LAST   = CNT_BITS'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RD,
        READ,
        WAIT_WR,
        WRITE,
        CFG,
        DONE
    } stateT;

    stateT                     state;
    stateT                     nextState;
    logic [CNT_BITS-1:0]       cnt;
    logic [ADDRESS_SIZE-1:0]   addrQ;
    logic [DATA_SIZE-1:0]      bcr;
    logic [DATA_SIZE-1:0]      rdQ;
    logic [DATA_SIZE-1:0]      mem [MEM_DEPTH];
    logic                      mtClkQ;
    logic                      reloadQ;

    logic                      accessStart;
    logic                      loadRead;
    logic                      commitWrite;
    logic                      bcrWrite;
    logic                      burstAdvance;
    logic                      driveBus;
    logic [MEM_ADDR_BITS-1:0]  memIdx;

    // Bits above the array and BCR width only matter for aliasing; they are latched but unused.
    logic unusedAddrBits;
    assign unusedAddrBits = ^addrQ[ADDRESS_SIZE-1:DATA_SIZE];

    assign memIdx = addrQ[MEM_ADDR_BITS-1:0];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nextState    = state;
        mt_wait      = 1'b0;
        driveBus     = 1'b0;
        accessStart  = 1'b0;
        loadRead     = 1'b0;
        commitWrite  = 1'b0;
        bcrWrite     = 1'b0;
        burstAdvance = 1'b0;

        unique case (state)
            IDLE: begin
                if (!mt_ce && !mt_adv) begin
                    accessStart = 1'b1;
                    if (mt_cre)      nextState = CFG;
                    else if (!mt_we) nextState = WAIT_WR;
                    else             nextState = WAIT_RD;
                end
            end
            WAIT_RD: begin
                mt_wait = 1'b1;
                if (cnt <= CNT_LAST) begin
                    nextState = READ;
                    loadRead  = 1'b1;
                end
            end
            WAIT_WR: begin
                mt_wait = 1'b1;
                if (cnt <= CNT_LAST) nextState = WRITE;
            end
            READ: begin
                driveBus     = !mt_oe && mt_we && !mt_ce;
                burstAdvance = !mt_ce && mt_adv && mt_clk && !mtClkQ;
            end
            WRITE: begin
                commitWrite = !mt_we && !mt_ce;
                nextState   = DONE;
            end
            CFG: begin
                driveBus = !mt_oe && mt_we && !mt_ce;
                if (!mt_we) begin
                    bcrWrite  = !mt_ce;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = DONE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // Deselect wins over everything: pending writes are dropped, reads aborted.
        if (mt_ce) nextState = IDLE;
    end

    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            addrQ   <= '0;
            bcr     <= BCR_RESET;
            mtClkQ  <= 1'b0;
            reloadQ <= 1'b0;
        end else begin
            mtClkQ  <= mt_clk;
            reloadQ <= burstAdvance;

            if (accessStart) begin
                addrQ <= mt_addr;
                if (!mt_cre) cnt <= mt_we ? CNT_BITS'(READ_LATENCY) : CNT_BITS'(WRITE_LATENCY);
            end else if (mt_wait) begin
                cnt <= cnt - 1'b1;
            end

            // Wrap inside the burst window; upper address bits stay put.
            if (burstAdvance) addrQ <= (addrQ & ~BURST_MASK) | ((addrQ + 1'b1) & BURST_MASK);

            if (bcrWrite) bcr <= addrQ[DATA_SIZE-1:0];
        end
    end

    // NOTE: the array and its read register have no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (commitWrite && !mt_lb) mem[memIdx][7:0]  <= mt_data[7:0];
        if (commitWrite && !mt_ub) mem[memIdx][15:8] <= mt_data[15:8];
        if (loadRead || reloadQ)   rdQ               <= mem[memIdx];
    end

    assign mt_data = driveBus ? ((state == CFG) ? bcr : rdQ) : 'z;

endmodule

// File: tb/tb_cellular_ram_responder.sv
// Directed bench for cellular_ram_responder: a byte-lane memory model feeds a
// scoreboard queue of expected read words that are popped when data is valid.
module tb_cellular_ram_responder;

    localparam int RL  = 4;
    localparam int WL  = 2;
    localparam int BL  = 4;
    localparam int MAB = 10;
    localparam logic [15:0] BUS_RELEASED = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] mt_addr;
    logic        mt_lb, mt_ub, mt_oe, mt_we, mt_ce, mt_adv, mt_cre, mt_clk;
    logic        mt_wait;
    wire  [15:0] mt_data;
    logic [15:0] tbData;
    logic        tbDrive;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model [int];
    logic [15:0] sbQ [$];
    logic [15:0] bcrModel;
    logic [15:0] lastExp;

    assign mt_data = tbDrive ? tbData : 16'hzzzz;
    pullup (mt_data);

    always #5 clk = ~clk;

    cellular_ram_responder #(
        .ADDRESS_SIZE (23),
        .DATA_SIZE    (16),
        .MEM_ADDR_BITS(MAB),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL),
        .BURST_LEN    (BL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mt_addr(mt_addr),
        .mt_data(mt_data),
        .mt_lb  (mt_lb),
        .mt_ub  (mt_ub),
        .mt_oe  (mt_oe),
        .mt_we  (mt_we),
        .mt_ce  (mt_ce),
        .mt_adv (mt_adv),
        .mt_cre (mt_cre),
        .mt_clk (mt_clk),
        .mt_wait(mt_wait)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelRead(input logic [22:0] a);
        int k = int'(a[MAB-1:0]);
        return model.exists(k) ? model[k] : 16'hxxxx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus();
        mt_ce = 1'b1; mt_adv = 1'b1; mt_we = 1'b1; mt_oe = 1'b1;
        mt_lb = 1'b1; mt_ub = 1'b1; mt_cre = 1'b0; tbDrive = 1'b0;
    endtask

    task automatic endAccess();
        idleBus();
        step();
    endtask

    task automatic ramWrite(input logic [22:0] a, input logic [15:0] d, input logic lb, input logic ub);
        int          k;
        logic [15:0] cur;
        mt_addr = a; mt_ce = 1'b0; mt_adv = 1'b0; mt_we = 1'b0; mt_oe = 1'b1;
        mt_cre = 1'b0; mt_lb = lb; mt_ub = ub; tbData = d; tbDrive = 1'b1;
        step();
        mt_adv = 1'b1;
        repeat (WL + 1) step();
        k   = int'(a[MAB-1:0]);
        cur = model.exists(k) ? model[k] : 16'hxxxx;
        if (!lb) cur[7:0]  = d[7:0];
        if (!ub) cur[15:8] = d[15:8];
        model[k] = cur;
        endAccess();
    endtask

    // Leaves the DUT in READ with the bench parked on a falling edge.
    task automatic ramRead(input logic [22:0] a, input string tag);
        int waits = 0;
        mt_addr = a; mt_ce = 1'b0; mt_adv = 1'b0; mt_we = 1'b1; mt_oe = 1'b0;
        mt_cre = 1'b0; tbDrive = 1'b0;
        sbQ.push_back(modelRead(a));
        step();
        mt_adv = 1'b1;
        @(negedge clk);
        while (mt_wait === 1'b1 && waits < 4 * RL) begin
            waits++;
            @(negedge clk);
        end
        check({tag, "_wait"}, 16'(waits), 16'(RL));
        lastExp = sbQ.pop_front();
        check({tag, "_data"}, mt_data, lastExp);
    endtask

    task automatic cfgRead(input string tag);
        mt_addr = '0; mt_ce = 1'b0; mt_adv = 1'b0; mt_cre = 1'b1; mt_we = 1'b1; mt_oe = 1'b0;
        tbDrive = 1'b0;
        step();
        mt_adv = 1'b1;
        @(negedge clk);
        check(tag, mt_data, bcrModel);
        endAccess();
    endtask

    task automatic cfgWrite(input logic [22:0] v);
        mt_addr = v; mt_ce = 1'b0; mt_adv = 1'b0; mt_cre = 1'b1; mt_we = 1'b0; mt_oe = 1'b1;
        tbDrive = 1'b0;
        step();
        mt_adv = 1'b1;
        step();
        bcrModel = v[15:0];
        endAccess();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [22:0] base;
        logic [22:0] start;

        rst = 1'b1; idleBus(); mt_addr = '0; mt_clk = 1'b0; tbData = '0;
        bcrModel = 16'h9D1F;
        #2 rst = 1'b0;
        #1;
        check("rst_wait", 16'(mt_wait), 16'h0000);
        check("rst_bus_released", mt_data, BUS_RELEASED);
        #19 rst = 1'b1;
        step();

        cfgRead("cfg_rd_reset");

        ramWrite(23'h005, 16'hA55A, 1'b0, 1'b0);
        ramRead(23'h005, "rd_full");
        endAccess();

        ramWrite(23'h005, 16'h1234, 1'b0, 1'b1);
        ramRead(23'h005, "rd_lower_only");
        endAccess();

        ramWrite(23'h005, 16'hFF00, 1'b1, 1'b0);
        ramRead(23'h005, "rd_upper_only");
        endAccess();

        for (int i = 0; i < BL; i++) ramWrite(23'(8 + i), 16'(i + 1), 1'b0, 1'b0);
        start = 23'h00A;
        base  = start & ~23'(BL - 1);
        ramRead(start, "burst_first");
        for (int i = 1; i <= BL; i++) begin
            sbQ.push_back(modelRead(base | ((start + 23'(i)) & 23'(BL - 1))));
            mt_clk = 1'b1;
            @(negedge clk);
            mt_clk = 1'b0;
            check("burst_hold", mt_data, lastExp);
            @(negedge clk);
            lastExp = sbQ.pop_front();
            check("burst_next", mt_data, lastExp);
        end

        // Deselect mid-read; re-selecting without mt_adv must leave the bus released.
        mt_ce = 1'b1;
        step();
        mt_ce = 1'b0;
        @(negedge clk);
        check("abort_rd_bus", mt_data, BUS_RELEASED);
        check("abort_rd_wait", 16'(mt_wait), 16'h0000);
        endAccess();

        ramWrite(23'h010, 16'h0000, 1'b0, 1'b0);
        mt_addr = 23'h010; mt_ce = 1'b0; mt_adv = 1'b0; mt_we = 1'b0; mt_oe = 1'b1;
        mt_lb = 1'b0; mt_ub = 1'b0; tbData = 16'hBEEF; tbDrive = 1'b1;
        step();
        mt_adv = 1'b1;
        @(negedge clk);
        check("abort_wr_wait_high", 16'(mt_wait), 16'h0001);
        mt_ce = 1'b1;
        step();
        @(negedge clk);
        check("abort_wr_wait_low", 16'(mt_wait), 16'h0000);
        idleBus();
        repeat (3) step();
        ramRead(23'h010, "abort_wr_readback");
        endAccess();

        cfgWrite(23'h001234);
        cfgRead("cfg_rd_written");

        ramWrite(23'h400, 16'h0F0F, 1'b0, 1'b0);
        ramRead(23'h000, "alias_rd");
        endAccess();

        // Reset during WAIT_WR must drop the write and clear mt_wait without a clock.
        ramWrite(23'h020, 16'h1111, 1'b0, 1'b0);
        mt_addr = 23'h020; mt_ce = 1'b0; mt_adv = 1'b0; mt_we = 1'b0; mt_oe = 1'b1;
        mt_lb = 1'b0; mt_ub = 1'b0; tbData = 16'h2222; tbDrive = 1'b1;
        step();
        mt_adv = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_mid_wait", 16'(mt_wait), 16'h0000);
        idleBus();
        #1 rst = 1'b1;
        repeat (4) step();
        ramRead(23'h020, "rst_mid_readback");
        endAccess();
        bcrModel = 16'h9D1F;
        cfgRead("cfg_rd_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
